seq_det_scheduler: RTL and testbench
====================================

// Module: seq_det_scheduler
// PURPOSE
//  Feeds parallel words, MSB first, one bit per cycle into an external serial Mealy
//  sequence detector (e.g. the 1101 non-overlapping detector) and counts its hits.
//  Owns the detector's clear line. Returns one hit count per word over a valid/ready
//  handshake. Optional continue mode lets a pattern span word boundaries.
// PARAMETERS
//  W      8  input word width, in bits. W >= 2.
//  CNT_W  4  hit-counter width. The counter saturates at 2**CNT_W-1.
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      reset, synchronous, active-low
//  in_valid   in   1      in_data/in_cont are valid
//  in_ready   out  1      controller can accept a word (IDLE only)
//  in_data    in   W      word to scan, MSB first
//  in_cont    in   1      1 = keep detector state from the previous word
//  det_clr    out  1      active-high synchronous clear to the detector
//  det_bit    out  1      serial bit to the detector's input
//  det_hit    in   1      detector Mealy output for the current det_bit (same cycle)
//  out_valid  out  1      out_count/out_sat are valid
//  out_ready  in   1      consumer accepts the result
//  out_count  out  CNT_W  number of hits in the word
//  out_sat    out  1      counter saturated during this word
// BEHAVIOUR
//  Reset (rst=0 at a clk edge):
//   - state=IDLE; in_ready=1; out_valid=0; out_count=0; out_sat=0; det_bit=0.
//   - primed=0. det_clr=1 for every cycle that rst=0.
//  FSM states: IDLE, CLR, SHIFT, DONE.
//   - IDLE: in_ready=1; det_clr=0; det_bit=0.
//     - On in_valid: latch in_data into sreg; idx=0; count=0; sat=0.
//     - Then go to SHIFT if (in_cont & primed), else go to CLR.
//   - CLR: det_clr=1 for exactly one cycle; det_bit=0; then go to SHIFT.
//   - SHIFT: det_bit=sreg[W-1]. Each cycle:
//     - If det_hit, increment count. At 2**CNT_W-1 the count holds and sat is set (sticky).
//     - Shift sreg left by 1; idx++.
//     - After the W-th bit (idx==W-1): primed=1; go to DONE.
//   - DONE: out_valid=1; out_count/out_sat are stable. On out_ready go to IDLE.
//     det_bit=0 and det_clr=0, so the detector state is held for continue mode.
//  Timing: word accepted at cycle T.
//   - First bit at T+2 (after CLR) or T+1 (continue mode).
//   - out_valid from T+2+W (or T+1+W) until the handshake completes.
//  det_hit is sampled only in SHIFT. det_hit in any other state is ignored.
//  Only one word is in flight at a time. in_valid outside IDLE is ignored (in_ready=0).
//  A word is not accepted in the same cycle as the out handshake; IDLE is always visited.
//  Reset mid-word: the word is aborted and no result is produced. The next word always
//   passes through CLR, regardless of in_cont.
//  The detector sees no bit activity except in SHIFT. The detector's state is a
//   function only of the bits streamed since its last clear.
// TESTING
//  1. in_data=8'b1101_1101, in_cont=0 -> det_clr high 1 cycle at T+1; bits 1,1,0,1,1,1,0,1
//     at T+2..T+9; out_valid at T+10 with out_count=2, out_sat=0.
//  2. Word 8'b0000_0110 then 8'b1000_0000 with in_cont=1 -> second out_count=1; first
//     bit at T+1. Repeat with in_cont=0 -> second out_count=0.
//  3. Hold out_ready=0 for 5 cycles in DONE -> out_valid, out_count stable; in_ready=0;
//     in_valid pulses are ignored; no extra word is counted.
//  4. CNT_W=1, in_data=8'b1101_1101 -> out_count=1, out_sat=1. Next word 8'h00 -> 0, 0.
//  5. rst=0 at the 4th SHIFT cycle -> next cycle: in_ready=1, out_valid=0, det_clr=1 while
//     rst=0. Next word with in_cont=1 still gets a CLR cycle.
//  6. First word after reset with in_cont=1, data 8'b1101_0000 -> CLR is inserted;
//     out_count=1.

Source files
------------

// File: rtl/seq_det_scheduler.sv
// Streams one parallel word at a time, MSB first, into an external serial Mealy detector,
// owns the detector's clear line, and returns the per-word hit count over a valid/ready pair.
module seq_det_scheduler #(
    parameter int W     = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_cont,
    output logic             det_clr,
    output logic             det_bit,
    input  logic             det_hit,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat
);

    localparam int                IDX_W    = (W > 1) ? $clog2(W) : 1;
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE,
        CLR,
        SHIFT,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       sreg_q, sreg_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               sat_q, sat_d;
    // Set once a full word has been streamed since the last clear; gates continue mode.
    logic               primed_q, primed_d;

    // NOTE: state registers take non-blocking assignments only, so every flop samples
    // the pre-edge value of its neighbours regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            sreg_q   <= '0;
            idx_q    <= '0;
            count_q  <= '0;
            sat_q    <= 1'b0;
            primed_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sreg_q   <= sreg_d;
            idx_q    <= idx_d;
            count_q  <= count_d;
            sat_q    <= sat_d;
            primed_q <= primed_d;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        idx_d     = idx_q;
        count_d   = count_q;
        sat_d     = sat_q;
        primed_d  = primed_q;
        in_ready  = 1'b0;
        det_clr   = ~rst;
        det_bit   = 1'b0;
        out_valid = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sreg_d  = in_data;
                    idx_d   = '0;
                    count_d = '0;
                    sat_d   = 1'b0;
                    state_d = (in_cont && primed_q) ? SHIFT : CLR;
                end
            end
            CLR: begin
                det_clr = 1'b1;
                state_d = SHIFT;
            end
            SHIFT: begin
                det_bit = rst & sreg_q[W-1];
                if (det_hit) begin
                    if (count_q == CNT_MAX) begin
                        sat_d = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
                sreg_d = {sreg_q[W-2:0], 1'b0};
                idx_d  = idx_q + IDX_W'(1);
                if (idx_q == IDX_LAST) begin
                    primed_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_count = count_q;
    assign out_sat   = sat_q;

endmodule

// File: tb/tb_seq_det_scheduler.sv
// Bench for seq_det_scheduler: two instances (wide and 1-bit counters) share one stimulus stream,
// each driving its own 1101 non-overlapping detector; results are scoreboarded against a bit-history model.
module tb_seq_det_scheduler;

    localparam int W     = 8;
    localparam int CW_A  = 4;
    localparam int CW_B  = 1;
    localparam int MAX_A = (1 << CW_A) - 1;
    localparam int MAX_B = (1 << CW_B) - 1;

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic [W-1:0]    in_data;
    logic            in_cont;
    logic            out_ready;

    logic            in_ready_a, det_clr_a, det_bit_a, det_hit_a, out_valid_a, out_sat_a;
    logic [CW_A-1:0] out_count_a;
    logic            in_ready_b, det_clr_b, det_bit_b, det_hit_b, out_valid_b, out_sat_b;
    logic [CW_B-1:0] out_count_b;

    always #5 clk = ~clk;

    seq_det_scheduler #(.W(W), .CNT_W(CW_A)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a), .in_data(in_data),
        .in_cont(in_cont), .det_clr(det_clr_a), .det_bit(det_bit_a), .det_hit(det_hit_a),
        .out_valid(out_valid_a), .out_ready(out_ready), .out_count(out_count_a), .out_sat(out_sat_a)
    );

    seq_det_scheduler #(.W(W), .CNT_W(CW_B)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b), .in_data(in_data),
        .in_cont(in_cont), .det_clr(det_clr_b), .det_bit(det_bit_b), .det_hit(det_hit_b),
        .out_valid(out_valid_b), .out_ready(out_ready), .out_count(out_count_b), .out_sat(out_sat_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: timeline of the current word plus the bit history since the last clear.
    int           cyc      = 0;
    bit           m_idle   = 1'b1;
    bit           primed   = 1'b0;
    int           sh_start = 0;
    int           done_at  = 0;
    int           clr_at   = -1;
    logic [W-1:0] m_word   = '0;
    int           n_acc    = 0;
    int           exp_q[$];
    bit           hist[$];
    logic         win;

    assign win = !m_idle && (cyc >= sh_start) && (cyc < sh_start + W);

    // Greedy non-overlapping scan of the history; counts matches ending inside the new word.
    function automatic int count_new(input int base);
        int i = 0;
        int n = 0;
        while (i + 3 < hist.size()) begin
            if (hist[i] && hist[i+1] && !hist[i+2] && hist[i+3]) begin
                if (i + 3 >= base) n++;
                i += 4;
            end else begin
                i++;
            end
        end
        return n;
    endfunction

    always @(posedge clk) begin : model
        bit clr;
        int base;
        cyc <= cyc + 1;
        if (!rst) begin
            m_idle <= 1'b1;
            primed <= 1'b0;
            clr_at <= -1;
            exp_q.delete();
            hist.delete();
        end else if (m_idle) begin
            if (in_valid) begin
                clr = !(in_cont && primed);
                if (clr) hist.delete();
                base = hist.size();
                for (int i = W - 1; i >= 0; i--) hist.push_back(in_data[i]);
                exp_q.push_back(count_new(base));
                m_word   <= in_data;
                clr_at   <= clr ? cyc + 1 : -1;
                sh_start <= cyc + (clr ? 2 : 1);
                done_at  <= cyc + (clr ? 2 : 1) + W;
                m_idle   <= 1'b0;
                primed   <= 1'b1;
                n_acc    <= n_acc + 1;
            end
        end else if (cyc >= done_at && out_ready) begin
            m_idle <= 1'b1;
        end
    end

    // External 1101 non-overlapping Mealy detectors; they advance only while bits stream.
    logic [1:0] prog_a = 2'd0;
    logic [1:0] prog_b = 2'd0;

    function automatic logic [1:0] det_next(input logic [1:0] p, input logic b);
        case (p)
            2'd0:    return b ? 2'd1 : 2'd0;
            2'd1:    return b ? 2'd2 : 2'd0;
            2'd2:    return b ? 2'd2 : 2'd3;
            default: return 2'd0;
        endcase
    endfunction

    assign det_hit_a = win && (prog_a == 2'd3) && det_bit_a;
    assign det_hit_b = win && (prog_b == 2'd3) && det_bit_b;

    always @(posedge clk) begin
        if (det_clr_a)  prog_a <= 2'd0;
        else if (win)   prog_a <= det_next(prog_a, det_bit_a);
        if (det_clr_b)  prog_b <= 2'd0;
        else if (win)   prog_b <= det_next(prog_b, det_bit_b);
    end

    // Monitor: per-cycle protocol checks and scoreboard comparison of presented results.
    always @(negedge clk) begin : monitor
        int   h;
        logic exp_clr;
        logic exp_bit;
        exp_clr = !rst || (!m_idle && cyc == clr_at);
        check("det_clr_a", det_clr_a, exp_clr);
        check("det_clr_b", det_clr_b, exp_clr);
        if (rst) begin
            exp_bit = win ? m_word[W - 1 - (cyc - sh_start)] : 1'b0;
            check("in_ready_a", in_ready_a, m_idle);
            check("in_ready_b", in_ready_b, m_idle);
            check("out_valid_a", out_valid_a, !m_idle && cyc >= done_at);
            check("out_valid_b", out_valid_b, !m_idle && cyc >= done_at);
            check("det_bit_a", det_bit_a, exp_bit);
            check("det_bit_b", det_bit_b, exp_bit);
            if (out_valid_a) begin
                check("pending_result", exp_q.size(), 1);
                if (exp_q.size() > 0) begin
                    h = exp_q[0];
                    check("out_count_a", out_count_a, (h > MAX_A) ? MAX_A : h);
                    check("out_sat_a", out_sat_a, h > MAX_A);
                    check("out_count_b", out_count_b, (h > MAX_B) ? MAX_B : h);
                    check("out_sat_b", out_sat_b, h > MAX_B);
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    // 0 = hold low, 1 = always ready, 2 = random backpressure
    int ready_mode = 1;

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_word(input logic [W-1:0] d, input bit c);
        int old = n_acc;
        bit ok  = 1'b0;
        in_data  = d;
        in_cont  = c;
        in_valid = 1'b1;
        for (int k = 0; k < 100; k++) begin
            tick();
            if (n_acc != old) begin
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        in_data  = W'($urandom);
        check("accept_timeout", ok, 1);
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (m_idle) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("idle_timeout", ok, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1);
    end

    logic [W-1:0] pats [6] = '{8'hDD, 8'h06, 8'h80, 8'h0D, 8'hD0, 8'h6D};

    initial begin
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_cont  = 1'b0;
        repeat (3) tick();
        check("reset_in_ready", in_ready_a, 1);
        check("reset_out_valid", out_valid_a, 0);
        check("reset_out_count", out_count_a, 0);
        check("reset_out_sat", out_sat_a, 0);
        check("reset_det_bit", det_bit_a, 0);
        rst = 1'b1;
        tick();

        // First word after reset asks for continue but still gets a clear cycle.
        send_word(8'b1101_0000, 1'b1);
        check("first_word_clr", det_clr_a, 1);
        wait_idle();

        send_word(8'b1101_1101, 1'b0);
        check("word_clr_cycle", det_clr_a, 1);
        wait_idle();
        send_word(8'h00, 1'b1);
        wait_idle();

        // Pattern spanning a word boundary, with and without continue.
        send_word(8'b0000_0110, 1'b0);
        wait_idle();
        send_word(8'b1000_0000, 1'b1);
        check("cont_no_clr", det_clr_a, 0);
        check("cont_first_bit", det_bit_a, 1);
        wait_idle();
        send_word(8'b0000_0110, 1'b0);
        wait_idle();
        send_word(8'b1000_0000, 1'b0);
        wait_idle();

        // Backpressure in DONE with ignored in_valid pulses.
        ready_mode = 0;
        tick();
        send_word(8'b1101_1101, 1'b0);
        repeat (W + 1) tick();
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_data  = W'($urandom);
            in_cont  = 1'b0;
            tick();
        end
        in_valid   = 1'b0;
        ready_mode = 1;
        wait_idle();
        repeat (3) tick();

        // Reset during the 4th shift cycle aborts the word.
        send_word(8'b1011_0110, 1'b0);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        check("midrst_in_ready", in_ready_a, 1);
        check("midrst_out_valid", out_valid_a, 0);
        check("midrst_det_clr", det_clr_a, 1);
        tick();
        rst = 1'b1;
        tick();
        send_word(8'b1101_0000, 1'b1);
        check("midrst_next_clr", det_clr_a, 1);
        wait_idle();

        // Randomized traffic with backpressure, continue mode and occasional resets.
        ready_mode = 2;
        for (int n = 0; n < 300; n++) begin
            logic [W-1:0] d;
            d = ($urandom_range(0, 2) == 0) ? pats[$urandom_range(0, 5)] : W'($urandom);
            send_word(d, 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 39) == 0) begin
                repeat ($urandom_range(0, 12)) tick();
                rst = 1'b0;
                tick();
                rst = 1'b1;
            end
            wait_idle();
            repeat ($urandom_range(0, 2)) tick();
        end

        ready_mode = 1;
        wait_idle();
        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
